ltsm_sb_handshake_tx: RTL and testbench

- Parametrised TX-side engine for a sideband (SB) request/response handshake inside an LTSM sub-state; successor to the fixed single-purpose TRAINERROR TX handshake.
- Sends a configurable REQ code and waits for the matching RESP code.
- Adds a response timeout with bounded retries, a partner-first mode, a sticky timeout flag, and a retry counter.
- Sits between the LTSM sub-state controller and the SB encoder/arbiter.

---
 rtl/ltsm_sb_pkg.sv | 19 +
 rtl/ltsm_timeout_timer.sv | 29 ++
 rtl/ltsm_sb_handshake_tx.sv | 126 ++++++++++++
 tb/tb_ltsm_sb_handshake_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ltsm_sb_pkg.sv
// Shared sideband definitions for the LTSM handshake engines.
// Holds message codes, FSM state encodings and timing defaults.
package ltsm_sb_pkg;

    localparam int SB_MSG_NONE            = 0;
    localparam int TRAINERROR_entry_resp  = 14;
    localparam int TRAINERROR_entry_req   = 15;

    // 8 ms at a 100 MHz sideband clock
    localparam int DEFAULT_TIMEOUT_CYCLES = 800000;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_RX   = 3'd1;
    localparam logic [2:0] ST_SEND_REQ  = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_TIMEOUT   = 3'd5;

endpackage

// File: rtl/ltsm_timeout_timer.sv
// Saturating response timer with clear/enable; o_expire flags the last counted cycle.
module ltsm_timeout_timer
    import ltsm_sb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    logic [TMR_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TMR_W'(TIMEOUT_CYCLES))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire = i_en && (r_cnt == TMR_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ltsm_sb_handshake_tx.sv
// TX side of an LTSM sideband REQ/RESP handshake with timeout, bounded retries
// and partner-first ordering.
module ltsm_sb_handshake_tx
    import ltsm_sb_pkg::*;
#(
    parameter int SB_MSG_WIDTH   = 4,
    parameter int REQ_MSG        = TRAINERROR_entry_req,
    parameter int RESP_MSG       = TRAINERROR_entry_resp,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = 2,
    parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1),
    parameter int RTY_W          = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_partner_req,
    input  logic                    i_rx_valid,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_tx,
    output logic                    o_valid_tx,
    output logic                    o_done,
    output logic                    o_timeout,
    output logic [RTY_W-1:0]        o_retry_cnt
);

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic                    w_retry_inc;
    logic                    w_resp_hit;
    logic                    w_expire;
    logic                    w_enter_send;
    logic                    w_tmr_clr;
    logic [SB_MSG_WIDTH-1:0] r_msg;
    logic                    r_valid;
    logic                    r_done;
    logic                    r_timeout;
    logic [RTY_W-1:0]        r_retry_cnt;

    assign w_resp_hit   = i_rx_msg_valid && (i_decoded_SB_msg == SB_MSG_WIDTH'(RESP_MSG));
    assign w_enter_send = (w_state_next == ST_SEND_REQ) && (r_state != ST_SEND_REQ);
    assign w_tmr_clr    = w_enter_send || (w_state_next == ST_IDLE);

    ltsm_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TMR_W          (TMR_W)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (r_state == ST_WAIT_RESP),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_retry_inc  = 1'b0;
        if (!i_en) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:      w_state_next = i_partner_req ? ST_WAIT_RX : ST_SEND_REQ;
                ST_WAIT_RX:   if (i_falling_edge_busy && i_rx_valid) w_state_next = ST_SEND_REQ;
                ST_SEND_REQ: begin
                    if (w_resp_hit)               w_state_next = ST_DONE;
                    else if (i_falling_edge_busy) w_state_next = ST_WAIT_RESP;
                end
                // A response arriving on the expiry cycle still completes the handshake
                ST_WAIT_RESP: begin
                    if (w_resp_hit) begin
                        w_state_next = ST_DONE;
                    end else if (w_expire) begin
                        if (r_retry_cnt < RTY_W'(MAX_RETRIES)) begin
                            w_state_next = ST_SEND_REQ;
                            w_retry_inc  = 1'b1;
                        end else begin
                            w_state_next = ST_TIMEOUT;
                        end
                    end
                end
                ST_DONE, ST_TIMEOUT: w_state_next = r_state;
                default:             w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_msg       <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_retry_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ST_IDLE) begin
                r_msg       <= '0;
                r_valid     <= 1'b0;
                r_done      <= 1'b0;
                r_timeout   <= 1'b0;
                r_retry_cnt <= '0;
            end else begin
                // The RX block may share the SB; keep the request up while it is talking
                if (w_enter_send) begin
                    r_msg   <= SB_MSG_WIDTH'(REQ_MSG);
                    r_valid <= 1'b1;
                end else if (i_falling_edge_busy && !i_rx_valid) begin
                    r_valid <= 1'b0;
                end
                if (w_retry_inc)                 r_retry_cnt <= r_retry_cnt + 1'b1;
                if (w_state_next == ST_DONE)     r_done      <= 1'b1;
                if (w_state_next == ST_TIMEOUT)  r_timeout   <= 1'b1;
            end
        end
    end

    assign o_encoded_SB_msg_tx = r_msg;
    assign o_valid_tx          = r_valid;
    assign o_done              = r_done;
    assign o_timeout           = r_timeout;
    assign o_retry_cnt         = r_retry_cnt;

endmodule

// File: tb/tb_ltsm_sb_handshake_tx.sv
// Directed bench for ltsm_sb_handshake_tx with a short timeout and two retries.
module tb_ltsm_sb_handshake_tx;

    logic       clk;
    logic       i_rst_n;
    logic       i_en;
    logic       i_partner_req;
    logic       i_rx_valid;
    logic       i_falling_edge_busy;
    logic       i_rx_msg_valid;
    logic [3:0] i_decoded_SB_msg;
    logic [3:0] o_encoded_SB_msg_tx;
    logic       o_valid_tx;
    logic       o_done;
    logic       o_timeout;
    logic [1:0] o_retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    ltsm_sb_handshake_tx #(
        .SB_MSG_WIDTH   (4),
        .REQ_MSG        (15),
        .RESP_MSG       (14),
        .TIMEOUT_CYCLES (16),
        .MAX_RETRIES    (2)
    ) dut (
        .i_clk               (clk),
        .i_rst_n             (i_rst_n),
        .i_en                (i_en),
        .i_partner_req       (i_partner_req),
        .i_rx_valid          (i_rx_valid),
        .i_falling_edge_busy (i_falling_edge_busy),
        .i_rx_msg_valid      (i_rx_msg_valid),
        .i_decoded_SB_msg    (i_decoded_SB_msg),
        .o_encoded_SB_msg_tx (o_encoded_SB_msg_tx),
        .o_valid_tx          (o_valid_tx),
        .o_done              (o_done),
        .o_timeout           (o_timeout),
        .o_retry_cnt         (o_retry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("  chk %s ok val=%0d", tag, got);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_valid"}, 32'(o_valid_tx), 32'd0);
        check_eq({tag, "_msg"},   32'(o_encoded_SB_msg_tx), 32'd0);
        check_eq({tag, "_done"},  32'(o_done), 32'd0);
        check_eq({tag, "_tmo"},   32'(o_timeout), 32'd0);
        check_eq({tag, "_rty"},   32'(o_retry_cnt), 32'd0);
    endtask

    task automatic busy_pulse();
        i_falling_edge_busy = 1'b1;
        @(negedge clk);
        i_falling_edge_busy = 1'b0;
    endtask

    // Counts negedges until the selected output rises (0 = o_valid_tx, 1 = o_timeout)
    task automatic wait_for(input int which, input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!((which == 0) ? o_valid_tx : o_timeout) && cycles < bound);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0; i_en = 1'b0; i_partner_req = 1'b0; i_rx_valid = 1'b0;
        i_falling_edge_busy = 1'b0; i_rx_msg_valid = 1'b0; i_decoded_SB_msg = 4'd0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        i_rst_n = 1'b1;

        // 1: plain handshake
        i_en = 1'b1;
        @(negedge clk);
        check_eq("t1_valid_lat1", 32'(o_valid_tx), 32'd1);
        check_eq("t1_msg_req",    32'(o_encoded_SB_msg_tx), 32'd15);
        busy_pulse();
        check_eq("t1_valid_clr",  32'(o_valid_tx), 32'd0);
        i_rx_msg_valid = 1'b1; i_decoded_SB_msg = 4'd14;
        @(negedge clk);
        i_rx_msg_valid = 1'b0; i_decoded_SB_msg = 4'd0;
        check_eq("t1_done",       32'(o_done), 32'd1);
        check_eq("t1_rty",        32'(o_retry_cnt), 32'd0);
        check_eq("t1_tmo",        32'(o_timeout), 32'd0);
        i_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("t1_abort");

        // 2: partner-first ordering
        i_en = 1'b1; i_partner_req = 1'b1;
        @(negedge clk);
        check_eq("t2_waitrx_valid", 32'(o_valid_tx), 32'd0);
        busy_pulse();
        check_eq("t2_busy_norx",    32'(o_valid_tx), 32'd0);
        i_rx_valid = 1'b1;
        busy_pulse();
        i_rx_valid = 1'b0; i_partner_req = 1'b0;
        check_eq("t2_valid",        32'(o_valid_tx), 32'd1);
        check_eq("t2_msg",          32'(o_encoded_SB_msg_tx), 32'd15);
        i_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("t2_abort");

        // 3: no response, two re-sends then timeout
        i_en = 1'b1;
        @(negedge clk);
        busy_pulse();
        wait_for(0, 40, cyc);
        check_eq("t3_resend1_lat", 32'(cyc), 32'd16);
        check_eq("t3_rty1",        32'(o_retry_cnt), 32'd1);
        busy_pulse();
        wait_for(0, 40, cyc);
        check_eq("t3_resend2_lat", 32'(cyc), 32'd16);
        check_eq("t3_rty2",        32'(o_retry_cnt), 32'd2);
        busy_pulse();
        wait_for(1, 40, cyc);
        check_eq("t3_tmo_lat",     32'(cyc), 32'd16);
        check_eq("t3_tmo",         32'(o_timeout), 32'd1);
        check_eq("t3_tmo_valid",   32'(o_valid_tx), 32'd0);
        check_eq("t3_tmo_rty",     32'(o_retry_cnt), 32'd2);
        repeat (5) @(negedge clk);
        check_eq("t3_tmo_sticky",  32'(o_timeout), 32'd1);
        check_eq("t3_no_reassert", 32'(o_valid_tx), 32'd0);
        i_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("t3_abort");

        // 4: response on the final expiry cycle
        i_en = 1'b1;
        @(negedge clk);
        busy_pulse();
        wait_for(0, 40, cyc);
        busy_pulse();
        wait_for(0, 40, cyc);
        check_eq("t4_rty2", 32'(o_retry_cnt), 32'd2);
        busy_pulse();
        repeat (15) @(negedge clk);
        i_rx_msg_valid = 1'b1; i_decoded_SB_msg = 4'd14;
        @(negedge clk);
        i_rx_msg_valid = 1'b0; i_decoded_SB_msg = 4'd0;
        check_eq("t4_done", 32'(o_done), 32'd1);
        check_eq("t4_tmo",  32'(o_timeout), 32'd0);
        i_en = 1'b0;
        @(negedge clk);

        // 5: shared-SB hold of o_valid_tx
        i_en = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b1;
        busy_pulse();
        check_eq("t5_hold",  32'(o_valid_tx), 32'd1);
        i_rx_valid = 1'b0;
        busy_pulse();
        check_eq("t5_clear", 32'(o_valid_tx), 32'd0);

        // 6: ignored messages, abort, asynchronous reset
        i_rx_msg_valid = 1'b1; i_decoded_SB_msg = 4'd13;
        @(negedge clk);
        check_eq("t6_wrong_code", 32'(o_done), 32'd0);
        i_rx_msg_valid = 1'b0; i_decoded_SB_msg = 4'd14;
        @(negedge clk);
        check_eq("t6_invalid",    32'(o_done), 32'd0);
        i_decoded_SB_msg = 4'd0;
        i_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("t6_abort");
        i_en = 1'b1;
        @(negedge clk);
        check_eq("t6_pre_rst_valid", 32'(o_valid_tx), 32'd1);
        #2 i_rst_n = 1'b0;
        #1;
        check_eq("t6_arst_valid", 32'(o_valid_tx), 32'd0);
        check_eq("t6_arst_msg",   32'(o_encoded_SB_msg_tx), 32'd0);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        check_eq("t6_recover_valid", 32'(o_valid_tx), 32'd1);
        i_rx_msg_valid = 1'b1; i_decoded_SB_msg = 4'd14;
        @(negedge clk);
        i_rx_msg_valid = 1'b0; i_decoded_SB_msg = 4'd0;
        check_eq("t6_resp_in_send", 32'(o_done), 32'd1);
        i_en = 1'b0;
        @(negedge clk);
        check_idle_outputs("end");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
